// File: rtl/instr_queue.sv
// instr_queue: circular instruction prefetch queue feeding a registered
// current-instruction register (instr / instr_valid).
// Optional feature macro: IQ_BYPASS_EN -- when defined, a simultaneous push
// and pop on an empty queue loads read_data straight into instr instead of
// writing it to storage.
module instr_queue #(
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_f,
    input  logic                         fill,
    input  logic [IW-1:0]                read_data,
    input  logic                         ir_load,
    input  logic                         flush,
    output logic [IW-1:0]                instr,
    output logic                         instr_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Storage: plain array, written without reset so it maps to RAM.
    logic [IW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [IW-1:0] instr_reg, instr_next;
    logic          instr_valid_reg, instr_valid_next;
    logic          overflow_reg, overflow_next;

    logic full_int;
    logic empty_int;
    logic bypass_hit;
    logic pop_ok;
    logic push_ok;
    logic push_drop;

    assign full_int  = (count_reg == CW'(DEPTH));
    assign empty_int = (count_reg == '0);

`ifdef IQ_BYPASS_EN
    // Empty queue with push and pop together: hand the word straight to instr.
    assign bypass_hit = fill && ir_load && empty_int;
`else
    assign bypass_hit = 1'b0;
`endif

    // A pop only consumes storage when something is stored.
    assign pop_ok    = ir_load && !empty_int;
    // When full, a push is still taken if the same-edge pop frees a slot.
    assign push_ok   = fill && (!full_int || ir_load) && !bypass_hit;
    assign push_drop = fill && full_int && !ir_load;

    // Next-state computation; flush wipes everything except the sticky overflow.
    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        instr_next       = instr_reg;
        instr_valid_next = instr_valid_reg;
        overflow_next    = overflow_reg;

        if (flush) begin
            wr_ptr_next      = '0;
            rd_ptr_next      = '0;
            count_next       = '0;
            instr_next       = '0;
            instr_valid_next = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (push_drop) begin
                overflow_next = 1'b1;
            end

            if (pop_ok) begin
                instr_next       = mem[rd_ptr_reg];
                instr_valid_next = 1'b1;
                rd_ptr_next      = rd_ptr_reg + PW'(1);
            end else if (bypass_hit) begin
                instr_next       = read_data;
                instr_valid_next = 1'b1;
            end else if (ir_load) begin
                // Pop on an empty queue: nothing live, keep the old word.
                instr_valid_next = 1'b0;
            end

            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            instr_reg       <= instr_next;
            instr_valid_reg <= instr_valid_next;
            overflow_reg    <= overflow_next;
        end
    end

    // Storage write port; suppressed under reset and flush so nothing lands.
    always_ff @(posedge clk) begin
        if (rst_f && !flush && push_ok) begin
            mem[wr_ptr_reg] <= read_data;
        end
    end

    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign count       = count_reg;
    assign full        = full_int;
    assign empty       = empty_int;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed stimulus with a scoreboard of hand-computed
// expected outputs, checked by an independent negedge monitor.
module tb_instr_queue;

    localparam int IW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_f = 1'b0;
    logic          fill = 1'b0;
    logic [IW-1:0] read_data = '0;
    logic          ir_load = 1'b0;
    logic          flush = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] e_instr;
        logic        e_valid;
        int          e_count;
        logic        e_ovf;
    } exp_t;

    exp_t exp_q[$];

    instr_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .fill        (fill),
        .read_data   (read_data),
        .ir_load     (ir_load),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: after each edge, compare every expectation due by now.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %0d %s instr=%h valid=%b count=%0d full=%b empty=%b ovf=%b",
                         e.cyc, e.name, instr, instr_valid, count, full, empty, overflow);
                check(e.name, "instr",    instr, e.e_instr);
                check(e.name, "valid",    {31'd0, instr_valid}, {31'd0, e.e_valid});
                check(e.name, "count",    {29'd0, count}, e.e_count);
                check(e.name, "full",     {31'd0, full},  {31'd0, (e.e_count == DEPTH)});
                check(e.name, "empty",    {31'd0, empty}, {31'd0, (e.e_count == 0)});
                check(e.name, "overflow", {31'd0, overflow}, {31'd0, e.e_ovf});
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic f, input logic [31:0] d, input logic ld,
                        input logic fl, input logic rs, input string nm,
                        input logic [31:0] ei, input logic ev, input int ec,
                        input logic eo);
        exp_t e;
        fill      = f;
        read_data = d;
        ir_load   = ld;
        flush     = fl;
        rst_f     = rs;
        e.cyc     = cyc_cnt + 1;
        e.name    = nm;
        e.e_instr = ei;
        e.e_valid = ev;
        e.e_count = ec;
        e.e_ovf   = eo;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 0, "reset0", 32'h0, 0, 0, 0);
        step(1, 32'hFFFF_FFFF, 1, 0, 0, "reset1", 32'h0, 0, 0, 0);

        // Basic order
        step(1, 32'hA000_0001, 0, 0, 1, "push_a1", 32'h0, 0, 1, 0);
        step(1, 32'hA000_0002, 0, 0, 1, "push_a2", 32'h0, 0, 2, 0);
        step(1, 32'hA000_0003, 0, 0, 1, "push_a3", 32'h0, 0, 3, 0);
        step(0, 0, 1, 0, 1, "pop_a1", 32'hA000_0001, 1, 2, 0);
        step(0, 0, 1, 0, 1, "pop_a2", 32'hA000_0002, 1, 1, 0);
        step(0, 0, 1, 0, 1, "pop_a3", 32'hA000_0003, 1, 0, 0);
        step(0, 0, 1, 0, 1, "pop_empty", 32'hA000_0003, 0, 0, 0);
        step(0, 0, 0, 0, 1, "idle_hold", 32'hA000_0003, 0, 0, 0);

        // Fill to full, overflow, push+pop at full
        step(1, 32'hB000_0001, 0, 0, 1, "push_b1", 32'hA000_0003, 0, 1, 0);
        step(1, 32'hB000_0002, 0, 0, 1, "push_b2", 32'hA000_0003, 0, 2, 0);
        step(1, 32'hB000_0003, 0, 0, 1, "push_b3", 32'hA000_0003, 0, 3, 0);
        step(1, 32'hB000_0004, 0, 0, 1, "push_b4", 32'hA000_0003, 0, 4, 0);
        step(1, 32'hB000_0005, 0, 0, 1, "push_drop", 32'hA000_0003, 0, 4, 1);
        step(1, 32'hC000_0006, 1, 0, 1, "pushpop_full", 32'hB000_0001, 1, 4, 1);
        step(0, 0, 1, 0, 1, "pop_b2", 32'hB000_0002, 1, 3, 1);
        step(0, 0, 1, 0, 1, "pop_b3", 32'hB000_0003, 1, 2, 1);
        step(0, 0, 1, 0, 1, "pop_b4", 32'hB000_0004, 1, 1, 1);
        step(0, 0, 1, 0, 1, "pop_c6", 32'hC000_0006, 1, 0, 1);
        step(0, 0, 1, 0, 1, "pop_empty2", 32'hC000_0006, 0, 0, 1);

        // Streaming through pointer wrap
        step(1, 32'hD000_0000, 0, 0, 1, "stream_d0", 32'hC000_0006, 0, 1, 1);
        for (int i = 1; i < 10; i++) begin
            step(1, 32'hD000_0000 + i, 1, 0, 1, "stream",
                 32'hD000_0000 + (i - 1), 1, 1, 1);
        end
        step(0, 0, 1, 0, 1, "stream_d9", 32'hD000_0009, 1, 0, 1);

        // Flush keeps overflow; then reset with count=2 and overflow=1
        step(1, 32'hE000_0000, 1, 1, 1, "flush_ovf", 32'h0, 0, 0, 1);
        step(1, 32'hE000_0001, 0, 0, 1, "push_e1", 32'h0, 0, 1, 1);
        step(1, 32'hE000_0002, 0, 0, 1, "push_e2", 32'h0, 0, 2, 1);
        step(1, 32'hE000_0003, 1, 0, 0, "reset_mid", 32'h0, 0, 0, 0);
        step(1, 32'hF000_0001, 0, 0, 1, "post_rst_push", 32'h0, 0, 1, 0);
        step(0, 0, 1, 0, 1, "post_rst_pop", 32'hF000_0001, 1, 0, 0);

        // Flush priority with count=3, instr_valid=1
        step(1, 32'h6000_0001, 0, 0, 1, "push_g1", 32'hF000_0001, 1, 1, 0);
        step(1, 32'h6000_0002, 0, 0, 1, "push_g2", 32'hF000_0001, 1, 2, 0);
        step(1, 32'h6000_0003, 0, 0, 1, "push_g3", 32'hF000_0001, 1, 3, 0);
        step(1, 32'h6000_0004, 0, 0, 1, "push_g4", 32'hF000_0001, 1, 4, 0);
        step(0, 0, 1, 0, 1, "pop_g1", 32'h6000_0001, 1, 3, 0);
        step(1, 32'h7777_7777, 1, 1, 1, "flush_prio", 32'h0, 0, 0, 0);
        step(0, 0, 1, 0, 1, "pop_after_flush", 32'h0, 0, 0, 0);

        // Empty-queue push+pop
`ifdef IQ_BYPASS_EN
        step(1, 32'h1234_5678, 1, 0, 1, "bypass", 32'h1234_5678, 1, 0, 0);
        step(0, 0, 1, 0, 1, "bypass_pop", 32'h1234_5678, 0, 0, 0);
`else
        step(1, 32'h1234_5678, 1, 0, 1, "no_bypass", 32'h0, 0, 1, 0);
        step(0, 0, 1, 0, 1, "no_bypass_pop", 32'h1234_5678, 1, 0, 0);
`endif

        fill    = 1'b0;
        ir_load = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard", "pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
